credit_tx_port: RTL
===================

Name: credit_tx_port

Overview:
- Transmitting end of the credit-based link used by every router port in the quadtree broadcasting network.
- Sits at a leaf/PE injection point and drives one router input (data valid + data), consuming the credit the router returns for each freed buffer slot.
- Buffers local flits in a small FIFO and only launches a flit when a downstream credit is held, so the router input buffer can never overflow.

Parameters:
DATA_WIDTH  `ROUTER_WIDTH (from router.vh)  flit width in bits
FIFO_DEPTH  4  local staging FIFO entries; power of 2, >= 2
CREDIT_MAX  4  downstream input buffer depth; initial and maximum credit count, >= 1

Ports:
clk  input  1  system clock
rst  input  1  system reset, synchronous, active high
tx_valid  input  1  local flit valid
tx_data  input  DATA_WIDTH  local flit payload
tx_ready  output  1  FIFO can accept; transfer when tx_valid & tx_ready
out_data_valid  output  1  flit valid toward router input, one-cycle pulse per flit
out_data  output  DATA_WIDTH  flit toward router input
in_credit  input  1  one credit returned by the router (one pulse = one slot freed)
credit_cnt  output  $clog2(CREDIT_MAX)+1  credits currently held
credit_err  output  1  sticky: credit returned while already at CREDIT_MAX
idle  output  1  FIFO empty, credit_cnt == CREDIT_MAX, out_data_valid low

Behaviour:
- One clock domain. Reset is synchronous and active-high; clock port clk, reset port rst.
- Reset values: FIFO empty, tx_ready = 1, out_data_valid = 0, out_data = 0, credit_cnt = CREDIT_MAX, credit_err = 0, idle = 1. Reset asserted mid-operation flushes the FIFO and any in-flight output on the next edge. It also restores the full credit count. The router on the same rst is reset together, so no credit reconciliation is performed.
- FIFO:
  - tx_ready = !full. It is a registered-state function only and is not combinationally dependent on tx_valid.
  - Write when tx_valid & tx_ready.
  - Read (send) when !empty & credit_cnt != 0.
  - Simultaneous read and write when full is not permitted: tx_ready is already low.
  - Simultaneous read and write at any other occupancy leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is $clog2(FIFO_DEPTH)+1.
- Send decision uses the registered credit_cnt only. A credit arriving in cycle N can enable a send no earlier than cycle N+1.
- Output register: on a send at edge E, out_data_valid = 1 and out_data = FIFO head for the cycle after E. With no send, out_data_valid = 0 and out_data holds its last value.
- Latency: a flit accepted in cycle N, with the FIFO empty and credit available, appears on out_data_valid in cycle N+2. Throughput is 1 flit/cycle while credits and data are available.
- Credit update each edge: credit_cnt_next = credit_cnt - send + in_credit.
  - Send and in_credit in the same cycle: count unchanged.
  - in_credit with credit_cnt == CREDIT_MAX and no send: count stays at CREDIT_MAX and credit_err sets. credit_err clears only on rst.
  - credit_cnt never underflows, because send requires credit_cnt != 0.
- Ordering: flits leave in strict FIFO order. No flit is dropped or duplicated.
- idle is combinational from registered state.

Test Plan:
- Reset then single flit: tx_data=0xA5 accepted in cycle 1 -> out_data_valid=1, out_data=0xA5 in cycle 3 only; credit_cnt 4->3; idle=0 until in_credit pulse, then credit_cnt=4, idle=1.
- Credit exhaustion: CREDIT_MAX=4, no in_credit, push 6 flits 1..6 -> exactly flits 1..4 emitted on consecutive cycles; credit_cnt=0; flits 5,6 held, FIFO count=2; one in_credit -> flit 5 emitted next-but-one cycle; credit_cnt returns to 0.
- Backpressure: credit_cnt=0, push until tx_ready=0 after exactly FIFO_DEPTH=4 accepts; a 5th tx_valid is not accepted; then return 4 credits -> 4 flits out in order; tx_ready reasserts the cycle after first read.
- Simultaneous send and credit: steady stream with in_credit asserted every cycle -> credit_cnt constant at 3, 1 flit/cycle sustained for 20 flits, order preserved.
- Credit overflow: at idle, pulse in_credit -> credit_cnt stays 4, credit_err=1 and stays 1 until rst; rst clears it to 0.
- Reset mid-stream: 3 flits queued, credit_cnt=1, assert rst for one cycle -> next cycle out_data_valid=0, tx_ready=1, credit_cnt=4, idle=1; no queued flit is ever emitted afterward.

Source files
------------

// File: rtl/credit_tx_port.sv
// Credit-based transmit port: stages local flits in a small FIFO and launches
// one toward the router input only while a downstream credit is held.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 8
`endif

module credit_tx_port #(
    parameter int DATA_WIDTH = `ROUTER_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int CREDIT_MAX = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            tx_valid,
    input  logic [DATA_WIDTH-1:0]           tx_data,
    output logic                            tx_ready,
    output logic                            out_data_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    input  logic                            in_credit,
    output logic [$clog2(CREDIT_MAX):0]     credit_cnt,
    output logic                            credit_err,
    output logic                            idle
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CREDIT_MAX) + 1;
    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CRED_FULL = CW'(CREDIT_MAX);

    logic [DATA_WIDTH-1:0] mem_p0 [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_p0;
    logic [AW-1:0]         rd_ptr_p0;
    logic [AW:0]           count_p0;
    logic [DATA_WIDTH-1:0] data_p1;
    logic                  vld_p1;

    logic                  full;
    logic                  empty;
    logic                  wr_en;
    logic                  send;
    logic [CW-1:0]         credit_nxt;
    logic                  credit_ovf;

    // Returns {overflow, next_count}; a credit returned at the ceiling is
    // dropped and flagged instead of wrapping the counter.
    function automatic logic [CW:0] credit_update(input logic [CW-1:0] cnt,
                                                  input logic          dec,
                                                  input logic          inc);
        logic [CW:0] res;
        res = {1'b0, cnt};
        if (inc && !dec) begin
            if (cnt == CRED_FULL) res = {1'b1, cnt};
            else                  res = {1'b0, cnt + CW'(1)};
        end else if (dec && !inc) begin
            res = {1'b0, cnt - CW'(1)};
        end
        return res;
    endfunction

    always_comb begin
        full  = (count_p0 == FIFO_FULL);
        empty = (count_p0 == '0);
        wr_en = tx_valid && !full;
        send  = !empty && (credit_cnt != '0);
        {credit_ovf, credit_nxt} = credit_update(credit_cnt, send, in_credit);
    end

    assign tx_ready       = !full;
    assign out_data_valid = vld_p1;
    assign out_data       = data_p1;
    assign idle           = empty && (credit_cnt == CRED_FULL) && !vld_p1;

    // Stage p0: staging FIFO storage (payload only, no reset needed)
    always_ff @(posedge clk) begin
        if (wr_en) mem_p0[wr_ptr_p0] <= tx_data;
    end

    // Stage p0: FIFO pointers, occupancy and credit state
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_p0  <= '0;
            rd_ptr_p0  <= '0;
            count_p0   <= '0;
            credit_cnt <= CRED_FULL;
            credit_err <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_p0 <= wr_ptr_p0 + AW'(1);
            if (send)  rd_ptr_p0 <= rd_ptr_p0 + AW'(1);
            case ({wr_en, send})
                2'b10:   count_p0 <= count_p0 + (AW+1)'(1);
                2'b01:   count_p0 <= count_p0 - (AW+1)'(1);
                default: count_p0 <= count_p0;
            endcase
            credit_cnt <= credit_nxt;
            if (credit_ovf) credit_err <= 1'b1;
        end
    end

    // Stage p1: output register toward the router input
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= send;
            if (send) data_p1 <= mem_p0[rd_ptr_p0];
        end
    end

endmodule
